// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits.
// Latency: word, flags and rx_valid update one clock after the last stop-bit sample.
// Backpressure: one holding register. A frame that completes while the word is unaccepted is dropped and pulses overrun.
// Ports: clk/rstn (async active-low); uart_rxd serial in (idle high);
//        rx_data/rx_valid/parity_err/frame_err held word + flags; rx_ready consumer accept; overrun drop pulse.
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(BPS_CNT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BPS_CNT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rxd_s1;
    logic                 rxd_s2;
    logic                 rxd_prev;
    logic [1:0]           warm;
    logic                 armed;
    logic                 par_pend;
    logic                 frm_pend;

    // FSM outputs
    logic cnt_clr;
    logic shift_en;
    logic par_en;
    logic stop_en;
    logic done;

    logic fall_edge;
    logic half_tick;
    logic bit_tick;
    logic exp_par;
    logic frm_now;

    // Two-stage synchroniser plus edge-history flop.
    // The flops come out of reset at 1, which would fake a falling edge if the line is
    // low at release (reset mid-frame). 'armed' only rises once the real line has been
    // observed high after the pipeline refilled, so the first frame needs a genuine edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
            warm     <= 2'd0;
            armed    <= 1'b0;
        end else begin
            rxd_s1   <= uart_rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
            if (warm != 2'd2) warm <= warm + 2'd1;
            armed    <= armed | ((warm == 2'd2) & rxd_s2);
        end
    end

    assign fall_edge = armed & rxd_prev & ~rxd_s2;
    assign half_tick = (cnt == CNT_HALF);
    assign bit_tick  = (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (fall_edge) state_nxt = S_START;
            S_START:  if (half_tick) state_nxt = rxd_s2 ? S_IDLE : S_DATA;
            S_DATA:   if (bit_tick && bit_idx == DATA_LAST)
                          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_tick) state_nxt = S_STOP;
            S_STOP:   if (bit_tick && bit_idx == STOP_LAST) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode: bit-sample strobes and counter control
    always_comb begin
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE:   cnt_clr = 1'b1;
            S_START:  cnt_clr = half_tick;
            S_DATA: begin
                cnt_clr  = bit_tick;
                shift_en = bit_tick;
            end
            S_PARITY: begin
                cnt_clr = bit_tick;
                par_en  = bit_tick;
            end
            S_STOP: begin
                cnt_clr = bit_tick;
                stop_en = bit_tick;
                done    = bit_tick && (bit_idx == STOP_LAST);
            end
            default:  cnt_clr = 1'b1;
        endcase
    end

    // Bit-period counter; restarting it at the start-bit midpoint aligns later samples mid-bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else              cnt <= cnt + 1'b1;
    end

    // Bit index is shared between data bits and stop bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_idx <= 4'd0;
        end else if (state == S_IDLE || state == S_START) begin
            bit_idx <= 4'd0;
        end else if (shift_en && bit_idx == DATA_LAST) begin
            bit_idx <= 4'd0;
        end else if (shift_en || stop_en) begin
            bit_idx <= bit_idx + 4'd1;
        end
    end

    // LSB arrives first, so shifting right leaves it at bit 0 after the last data bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         shift_reg <= '0;
        else if (shift_en) shift_reg <= {rxd_s2, shift_reg[DATA_BITS-1:1]};
    end

    assign exp_par = (PARITY == 1) ? ~(^shift_reg) : (^shift_reg);
    // The final stop sample is seen on the completion cycle itself, before frm_pend can record it.
    assign frm_now = frm_pend | (stop_en & ~rxd_s2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_pend <= 1'b0;
            frm_pend <= 1'b0;
        end else if (state == S_START) begin
            par_pend <= 1'b0;
            frm_pend <= 1'b0;
        end else begin
            if (par_en && (rxd_s2 != exp_par)) par_pend <= 1'b1;
            if (stop_en && !rxd_s2)            frm_pend <= 1'b1;
        end
    end

    // Holding register. A new word loads when the slot is empty or is being accepted
    // this same cycle; otherwise it is dropped and the old word stays intact.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift_reg;
                    parity_err <= par_pend;
                    frame_err  <= frm_now;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

    localparam int BA = 434;  // 50 MHz / 115200
    localparam int BB = 16;   // 1.6 MHz / 100000

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       rxd_a, rxd_b, rxd_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic       vld_a, vld_b, vld_c;
    logic       perr_a, perr_b, perr_c;
    logic       ferr_a, ferr_b, ferr_c;
    logic       ovr_a, ovr_b, ovr_c;

    int total = 0;
    int bad   = 0;
    int ovr_cnt_a = 0;

    // Accepted words as {parity_err, frame_err, 9-bit data}
    logic [10:0] got_a[$];
    logic [10:0] got_b[$];
    logic [10:0] got_c[$];

    uart_rx_cfg u_a (
        .clk(clk), .rstn(rstn), .uart_rxd(rxd_a), .rx_data(data_a), .rx_valid(vld_a),
        .rx_ready(rdy_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a)
    );

    uart_rx_cfg #(.CLK_FREQ(1600000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .rstn(rstn), .uart_rxd(rxd_b), .rx_data(data_b), .rx_valid(vld_b),
        .rx_ready(rdy_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b)
    );

    uart_rx_cfg #(.CLK_FREQ(1600000), .UART_BPS(100000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
        .clk(clk), .rstn(rstn), .uart_rxd(rxd_c), .rx_data(data_c), .rx_valid(vld_c),
        .rx_ready(rdy_c), .parity_err(perr_c), .frame_err(ferr_c), .overrun(ovr_c)
    );

    always @(negedge clk) begin
        if (vld_a && rdy_a) got_a.push_back({perr_a, ferr_a, 1'b0, data_a});
        if (vld_b && rdy_b) got_b.push_back({perr_b, ferr_b, 1'b0, data_b});
        if (vld_c && rdy_c) got_c.push_back({perr_c, ferr_c, 2'b00, data_c});
        if (ovr_a) ovr_cnt_a++;
    end

    // ---------------- reference model ----------------
    // Line image of a frame: start 0, data LSB first, optional parity, stop bits.
    function automatic void build(input logic [8:0] d, input int nb, input int np, input logic pb,
                                  input int ns, input logic [1:0] sv,
                                  output logic [15:0] bits, output int n);
        bits = '1;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin bits[n] = d[i]; n++; end
        if (np != 0) begin bits[n] = pb; n++; end
        for (int i = 0; i < ns; i++) begin bits[n] = sv[i]; n++; end
    endfunction

    // Even parity: total ones including parity bit must be even; odd: must be odd.
    function automatic logic exp_perr(input logic [8:0] d, input logic pb, input int mode);
        int ones;
        ones = $countones(d) + int'(pb);
        if (mode == 2) return (ones % 2) != 0;
        return (ones % 2) != 1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_line(input int inst, input logic v);
        case (inst)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    task automatic send(input int inst, input logic [8:0] d, input int nb, input int np, input logic pb,
                        input int ns, input logic [1:0] sv, input int bps);
        logic [15:0] b;
        int n;
        build(d, nb, np, pb, ns, sv, b, n);
        for (int i = 0; i < n; i++) begin
            set_line(inst, b[i]);
            repeat (bps) @(negedge clk);
        end
        set_line(inst, 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (vld_a !== 1'b0 || data_a !== 8'h00) begin bad++; $display("FAIL reset_a: vld=%b data=%h want 0/00", vld_a, data_a); end
        total++; if (perr_a !== 1'b0 || ferr_a !== 1'b0 || ovr_a !== 1'b0) begin bad++; $display("FAIL reset_a_flags: p=%b f=%b o=%b want 000", perr_a, ferr_a, ovr_a); end
        total++; if (vld_b !== 1'b0 || data_b !== 8'h00 || perr_b !== 1'b0) begin bad++; $display("FAIL reset_b: vld=%b data=%h p=%b want 0/00/0", vld_b, data_b, perr_b); end
        total++; if (vld_c !== 1'b0 || data_c !== 7'h00 || ferr_c !== 1'b0) begin bad++; $display("FAIL reset_c: vld=%b data=%h f=%b want 0/00/0", vld_c, data_c, ferr_c); end
        rstn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic;
        got_a.delete();
        send(0, 9'h055, 8, 0, 1'b0, 1, 2'b11, BA);
        repeat (2 * BA) @(negedge clk);
        total++; if (got_a.size() != 1) begin bad++; $display("FAIL basic_count: got %0d words want 1", got_a.size()); end
        else begin
            total++; if (got_a[0] !== {2'b00, 9'h055}) begin bad++; $display("FAIL basic_word: got %h want %h", got_a[0], {2'b00, 9'h055}); end
        end
    endtask

    task automatic test_parity;
        logic [10:0] e0, e1;
        got_b.delete();
        e0 = {exp_perr(9'h0A3, 1'b1, 2), 1'b0, 9'h0A3};
        e1 = {exp_perr(9'h0A3, 1'b0, 2), 1'b0, 9'h0A3};
        send(1, 9'h0A3, 8, 1, 1'b1, 1, 2'b11, BB);
        repeat (BB) @(negedge clk);
        send(1, 9'h0A3, 8, 1, 1'b0, 1, 2'b11, BB);
        repeat (3 * BB) @(negedge clk);
        total++; if (got_b.size() != 2) begin bad++; $display("FAIL parity_count: got %0d words want 2", got_b.size()); end
        else begin
            total++; if (got_b[0] !== e0) begin bad++; $display("FAIL parity_bad_bit: got %h want %h", got_b[0], e0); end
            total++; if (got_b[1] !== e1) begin bad++; $display("FAIL parity_good_bit: got %h want %h", got_b[1], e1); end
        end
    endtask

    task automatic test_break;
        got_a.delete();
        send(0, 9'h03C, 8, 0, 1'b0, 1, 2'b00, BA);
        set_line(0, 1'b0);
        repeat (5 * BA) @(negedge clk);
        total++; if (got_a.size() != 1) begin bad++; $display("FAIL break_low_count: got %0d words want 1", got_a.size()); end
        set_line(0, 1'b1);
        repeat (2 * BA) @(negedge clk);
        total++; if (got_a.size() != 1) begin bad++; $display("FAIL break_count: got %0d words want 1", got_a.size()); end
        else begin
            total++; if (got_a[0] !== {2'b01, 9'h03C}) begin bad++; $display("FAIL break_word: got %h want %h", got_a[0], {2'b01, 9'h03C}); end
        end
    endtask

    task automatic test_glitch;
        got_a.delete();
        set_line(0, 1'b0);
        repeat (100) @(negedge clk);
        set_line(0, 1'b1);
        repeat (2 * BA) @(negedge clk);
        total++; if (got_a.size() != 0) begin bad++; $display("FAIL glitch_count: got %0d words want 0", got_a.size()); end
        send(0, 9'h081, 8, 0, 1'b0, 1, 2'b11, BA);
        repeat (2 * BA) @(negedge clk);
        total++; if (got_a.size() != 1) begin bad++; $display("FAIL glitch_next_count: got %0d words want 1", got_a.size()); end
        else begin
            total++; if (got_a[0] !== {2'b00, 9'h081}) begin bad++; $display("FAIL glitch_next_word: got %h want %h", got_a[0], {2'b00, 9'h081}); end
        end
    endtask

    task automatic test_overrun;
        got_a.delete();
        rdy_a = 1'b0;
        ovr_cnt_a = 0;
        send(0, 9'h011, 8, 0, 1'b0, 1, 2'b11, BA);
        repeat (BA) @(negedge clk);
        send(0, 9'h022, 8, 0, 1'b0, 1, 2'b11, BA);
        repeat (2 * BA) @(negedge clk);
        total++; if (vld_a !== 1'b1 || data_a !== 8'h11) begin bad++; $display("FAIL overrun_hold: vld=%b data=%h want 1/11", vld_a, data_a); end
        total++; if (ovr_cnt_a != 1) begin bad++; $display("FAIL overrun_pulse: %0d cycles want 1", ovr_cnt_a); end
        rdy_a = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL overrun_drain_vld: vld=%b want 0", vld_a); end
        total++; if (got_a.size() != 1) begin bad++; $display("FAIL overrun_drain_count: got %0d words want 1", got_a.size()); end
        else begin
            total++; if (got_a[0] !== {2'b00, 9'h011}) begin bad++; $display("FAIL overrun_drain_word: got %h want %h", got_a[0], {2'b00, 9'h011}); end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        d = 8'hF0;
        got_a.delete();
        set_line(0, 1'b0);
        repeat (BA) @(negedge clk);
        for (int i = 0; i < 2; i++) begin set_line(0, d[i]); repeat (BA) @(negedge clk); end
        set_line(0, d[2]);
        repeat (200) @(negedge clk);
        rstn = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (vld_a !== 1'b0 || data_a !== 8'h00) begin bad++; $display("FAIL midreset_outputs: vld=%b data=%h want 0/00", vld_a, data_a); end
        rstn = 1'b1;
        repeat (BA - 205) @(negedge clk);
        for (int i = 3; i < 8; i++) begin set_line(0, d[i]); repeat (BA) @(negedge clk); end
        set_line(0, 1'b1);
        repeat (2 * BA) @(negedge clk);
        send(0, 9'h00F, 8, 0, 1'b0, 1, 2'b11, BA);
        repeat (2 * BA) @(negedge clk);
        total++; if (got_a.size() != 1) begin bad++; $display("FAIL midreset_count: got %0d words want 1", got_a.size()); end
        else begin
            total++; if (got_a[0] !== {2'b00, 9'h00F}) begin bad++; $display("FAIL midreset_word: got %h want %h", got_a[0], {2'b00, 9'h00F}); end
        end
    endtask

    // Random 8E1 frames, some with wrong parity or a low stop bit, mostly back to back.
    task automatic test_random_b;
        logic [10:0] exp_q[$];
        logic [8:0]  d;
        logic        pb, st;
        got_b.delete();
        for (int k = 0; k < 20; k++) begin
            d  = 9'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            exp_q.push_back({exp_perr(d, pb, 2), ~st, d});
            send(1, d, 8, 1, pb, 1, {1'b1, st}, BB);
            if (!st) repeat (BB) @(negedge clk);
            else     repeat ($urandom_range(0, 1) * BB) @(negedge clk);
        end
        repeat (3 * BB) @(negedge clk);
        total++; if (got_b.size() != exp_q.size()) begin bad++; $display("FAIL rand_b_count: got %0d want %0d", got_b.size(), exp_q.size()); end
        else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                total++; if (got_b[k] !== exp_q[k]) begin bad++; $display("FAIL rand_b_word%0d: got %h want %h", k, got_b[k], exp_q[k]); end
            end
        end
    endtask

    // Random 7O2 frames; a gap follows any frame whose final stop bit is low.
    task automatic test_random_c;
        logic [10:0] exp_q[$];
        logic [8:0]  d;
        logic        pb;
        logic [1:0]  sv;
        got_c.delete();
        for (int k = 0; k < 20; k++) begin
            d  = 9'($urandom_range(0, 127));
            pb = 1'($urandom_range(0, 1));
            sv = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            exp_q.push_back({exp_perr(d, pb, 1), (sv != 2'b11), d});
            send(2, d, 7, 1, pb, 2, sv, BB);
            if (!sv[1]) repeat (BB) @(negedge clk);
            else        repeat ($urandom_range(0, 1) * BB) @(negedge clk);
        end
        repeat (3 * BB) @(negedge clk);
        total++; if (got_c.size() != exp_q.size()) begin bad++; $display("FAIL rand_c_count: got %0d want %0d", got_c.size(), exp_q.size()); end
        else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                total++; if (got_c[k] !== exp_q[k]) begin bad++; $display("FAIL rand_c_word%0d: got %h want %h", k, got_c[k], exp_q[k]); end
            end
        end
    endtask

    initial begin
        rstn  = 1'b0;
        rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
        rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
        test_reset;
        test_basic;
        test_parity;
        test_break;
        test_glitch;
        test_overrun;
        test_reset_mid;
        test_random_b;
        test_random_c;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200, meaning line baud rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock; all state on rising edge.
REQ-007 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port uart_rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data, output, DATA_BITS bits: received word, LSB first on line.
REQ-010 SHALL have port rx_valid, output, 1 bit: rx_data and error flags are valid.
REQ-011 SHALL have port rx_ready, input, 1 bit: consumer accepts the word when high with rx_valid.
REQ-012 SHALL have port parity_err, output, 1 bit: parity mismatch on the held word; qualified by rx_valid.
REQ-013 SHALL have port frame_err, output, 1 bit: a stop bit sampled low on the held word; qualified by rx_valid.
REQ-014 SHALL have port overrun, output, 1 bit: one-cycle pulse when a frame completes while the holding register is occupied.

Function
REQ-015 SHALL define BPS_CNT = CLK_FREQ/UART_BPS (integer division); counter width SHALL be $clog2(BPS_CNT).
REQ-016 SHALL synchronise uart_rxd through two flops reset to 1; all sampling SHALL use the second flop.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL leave IDLE for START only on a synchronised falling edge (previous 1, current 0).
REQ-019 In START, SHALL sample at count BPS_CNT/2; if low -> DATA with counter cleared; if high (glitch) -> IDLE with nothing reported.
REQ-020 In DATA/PARITY/STOP, SHALL sample once per bit when the counter reaches BPS_CNT-1, then clear the counter (mid-bit alignment).
REQ-021 DATA SHALL shift in exactly DATA_BITS samples LSB first; then -> PARITY if PARITY!=0, else -> STOP.
REQ-022 PARITY SHALL compare the sample with the XOR of the data bits (even) or its inverse (odd); a mismatch sets the pending parity error.
REQ-023 STOP SHALL sample STOP_BITS bits; any low sample sets the pending frame error; after the last stop sample -> IDLE.
REQ-024 Completion SHALL occur on the cycle of the last stop sample; rx_valid/rx_data/errors SHALL update on the next edge (1-cycle latency).
REQ-025 On completion with rx_valid low, or rx_valid high and rx_ready high, the new word and flags SHALL load and rx_valid SHALL be 1.
REQ-026 On completion with rx_valid high and rx_ready low, the new word SHALL be dropped, held data SHALL be unchanged, and overrun SHALL pulse 1 cycle.
REQ-027 rx_valid && rx_ready without completion SHALL clear rx_valid; rx_data and flags MAY hold stale values.
REQ-028 After a frame error with the line still low (break), SHALL stay in IDLE until a new falling edge is seen.
REQ-029 Counter SHALL be held at 0 in IDLE.

Reset
REQ-030 rstn low SHALL asynchronously force: FSM = IDLE, counter = 0, sync flops = 1, rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL require a fresh falling edge.

Verification
REQ-032 8N1, BPS_CNT=434, send 0x55, rx_ready=1 -> one rx_valid with rx_data=0x55, parity_err=0, frame_err=0.
REQ-033 PARITY=2, send 0xA3 with parity bit 1 -> rx_data=0xA3, parity_err=1; repeat with parity bit 0 -> parity_err=0.
REQ-034 Send 0x3C with stop bit 0, then hold line low 5 bit times -> frame_err=1 once; no second frame while low.
REQ-035 Drive uart_rxd low for 100 cycles, then high -> no rx_valid; a following 0x81 frame is received correctly.
REQ-036 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11 and overrun pulses exactly 1 cycle.
REQ-037 Assert rstn mid-data-bit of frame 0xF0, release, then send 0x0F -> only 0x0F reported.
